// File: rtl/ext_code_seq_param.sv
// -----------------------------------------------------------------------------
// ext_code_seq_param
//
// External-trigger code sequencer. Holds DEPTH code words of CODE_W bits.
// While the (synchronised) external trigger is high, the word at the current
// run index is driven on oCode. On each trigger fall the run index steps
// down, up or holds, with wrap-around or stop-and-flag at the end of range.
//
// Ports
//   iClk             system clock
//   iRst             asynchronous, active-high reset
//   iSET_CODE_FLAG   1-cycle write strobe: storage[iSET_ADDR] <= iSET_CODE
//   iSET_CODE        write data
//   iSET_ADDR        write address (independent of the run index)
//   iSET_INDEX_FLAG  1-cycle strobe: index <= iSET_INDEX, clears oDone
//   iSET_INDEX       run index to load
//   iMODE            00 count down, 01 count up, 1x hold
//   iWRAP            1 wrap modulo DEPTH, 0 stop at end and raise oDone
//   iTrigger         asynchronous external trigger (high = output active)
//   oCode            storage[index] while active, else 0 (registered)
//   oIndex           current run index
//   oDone            sequence exhausted (stop mode only)
//   oState           sequencer state (0 idle, 1 active, 2 done) for observation
//
// Handshake: there is no valid/ready pair. Both strobes are single-cycle
// pulses that are acted on at the next rising clock edge; they are always
// accepted and never back-pressured.
// -----------------------------------------------------------------------------
module ext_code_seq_param #(
    parameter int CODE_W      = 32,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iSET_CODE_FLAG,
    input  logic [CODE_W-1:0] iSET_CODE,
    input  logic [IDX_W-1:0]  iSET_ADDR,
    input  logic              iSET_INDEX_FLAG,
    input  logic [IDX_W-1:0]  iSET_INDEX,
    input  logic [1:0]        iMODE,
    input  logic              iWRAP,
    input  logic              iTrigger,
    output logic [CODE_W-1:0] oCode,
    output logic [IDX_W-1:0]  oIndex,
    output logic              oDone,
    output logic [1:0]        oState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Trigger synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_q;
    logic                   trig_s;
    logic                   trig_rise;
    logic                   trig_fall;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_q <= '0;
            trig_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iTrigger};
            trig_q <= trig_s;
        end
    end

    assign trig_s    = sync_q[SYNC_STAGES-1];
    assign trig_rise = trig_s & ~trig_q;
    assign trig_fall = ~trig_s & trig_q;

    // ------------------------------------------------------------------
    // Code storage. Deliberately not reset: contents are only meaningful
    // once written, and keeping them across a reset lets the host re-run a
    // sequence without reloading it.
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge iClk) begin
        if (iSET_CODE_FLAG) begin
            mem_q[iSET_ADDR] <= iSET_CODE;
        end
    end

    // ------------------------------------------------------------------
    // Step computation for the trigger fall. Mode and wrap are taken from
    // the inputs in the cycle the step is applied, so a change during a
    // pulse only affects that pulse's closing step.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] index_d;
    logic [IDX_W-1:0] step_index;
    logic             step_done;
    logic             at_low;
    logic             at_high;

    assign at_low  = (index_q == '0);
    assign at_high = (index_q == IDX_W'(DEPTH - 1));

    always_comb begin
        step_index = index_q;
        step_done  = 1'b0;
        if (iMODE[1]) begin
            // Hold: index unchanged and never exhausts.
            step_index = index_q;
        end else if (iMODE[0]) begin
            if (at_high) begin
                if (iWRAP) begin
                    step_index = '0;
                end else begin
                    step_done = 1'b1;
                end
            end else begin
                step_index = index_q + IDX_W'(1);
            end
        end else begin
            if (at_low) begin
                if (iWRAP) begin
                    step_index = IDX_W'(DEPTH - 1);
                end else begin
                    step_done = 1'b1;
                end
            end else begin
                step_index = index_q - IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] rd_word;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            code_q  <= code_d;
        end
    end

    // A write to the word currently being driven is forwarded so that it
    // shows on oCode at the same edge that updates the storage.
    always_comb begin
        rd_word = mem_q[index_q];
        if (iSET_CODE_FLAG && (iSET_ADDR == index_q)) begin
            rd_word = iSET_CODE;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        code_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (trig_fall) begin
                    state_d = ST_IDLE;
                    // An index load in the same cycle overrides the step.
                    if (!iSET_INDEX_FLAG) begin
                        index_d = step_index;
                        if (step_done) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Triggers are ignored until the index is reloaded.
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (iSET_INDEX_FLAG) begin
            index_d = iSET_INDEX;
            // Leaving DONE goes to IDLE: the sequencer restarts on the
            // next fresh trigger rise rather than mid-pulse.
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end

        // Output follows the next state so that the code leaves/returns to
        // zero on the same edge that the step and state change happen.
        if (state_d == ST_ACTIVE) begin
            code_d = rd_word;
        end
    end

    assign oCode  = code_q;
    assign oIndex = index_q;
    assign oDone  = (state_q == ST_DONE);
    assign oState = state_q;

endmodule
